// File: rtl/mem_wb_if.sv
// Bundle of upstream handshake, data-memory bus and register-file writeback for mem_wb_stage.
// master = the stage itself, slave = its surroundings (ALU stage, memory, register file).
interface mem_wb_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [WIDTH-1:0]  in_result;
  logic [WIDTH-1:0]  in_store_data;
  logic [REG_W-1:0]  in_rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;
  logic              wb_en;
  logic [REG_W-1:0]  wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              mem_err;

  modport master (
    input  in_valid, in_opcode, in_result, in_store_data, in_rd, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, mem_err
  );

  modport slave (
    output in_valid, in_opcode, in_result, in_store_data, in_rd, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, mem_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: ALU ops write back directly, LOAD/STR run a req/ack memory
// transaction with a timeout abort. Every output is a register.
module mem_wb_stage #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input logic      clk,
  input logic      rst_n,
  mem_wb_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t            state_r,     state_nxt_s;
  logic              in_ready_r,  in_ready_nxt_s;
  logic              mem_req_r,   mem_req_nxt_s;
  logic              mem_we_r,    mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_nxt_s;
  logic [WIDTH-1:0]  mem_wdata_r, mem_wdata_nxt_s;
  logic [REG_W-1:0]  rd_r,        rd_nxt_s;
  logic              wb_en_r,     wb_en_nxt_s;
  logic [REG_W-1:0]  wb_addr_r,   wb_addr_nxt_s;
  logic [WIDTH-1:0]  wb_data_r,   wb_data_nxt_s;
  logic              mem_err_r,   mem_err_nxt_s;
  logic [CNT_W-1:0]  cnt_r,       cnt_nxt_s;

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    state_nxt_s     = state_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    rd_nxt_s        = rd_r;
    wb_en_nxt_s     = 1'b0;
    wb_addr_nxt_s   = wb_addr_r;
    wb_data_nxt_s   = wb_data_r;
    mem_err_nxt_s   = 1'b0;
    cnt_nxt_s       = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_opcode)
            OP_ADD, OP_SUB: begin
              wb_en_nxt_s   = 1'b1;
              wb_addr_nxt_s = bus.in_rd;
              wb_data_nxt_s = bus.in_result;
              state_nxt_s   = ST_WB;
            end
            OP_LOAD, OP_STR: begin
              mem_req_nxt_s   = 1'b1;
              mem_we_nxt_s    = (bus.in_opcode == OP_STR);
              mem_addr_nxt_s  = bus.in_result[ADDR_W-1:0];
              mem_wdata_nxt_s = bus.in_store_data;
              rd_nxt_s        = bus.in_rd;
              cnt_nxt_s       = {CNT_W{1'b0}};
              state_nxt_s     = ST_MEM;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEM: begin
        // An ack on the timeout boundary cycle is checked first so it completes normally.
        if (bus.mem_ack) begin
          mem_req_nxt_s = 1'b0;
          if (mem_we_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            wb_en_nxt_s   = 1'b1;
            wb_addr_nxt_s = rd_r;
            wb_data_nxt_s = bus.mem_rdata;
            state_nxt_s   = ST_WB;
          end
        end else if (cnt_r == CNT_LAST) begin
          mem_req_nxt_s = 1'b0;
          mem_err_nxt_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WB: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        mem_req_nxt_s = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
    in_ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
      rd_r        <= {REG_W{1'b0}};
      wb_en_r     <= 1'b0;
      wb_addr_r   <= {REG_W{1'b0}};
      wb_data_r   <= {WIDTH{1'b0}};
      mem_err_r   <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      rd_r        <= rd_nxt_s;
      wb_en_r     <= wb_en_nxt_s;
      wb_addr_r   <= wb_addr_nxt_s;
      wb_data_r   <= wb_data_nxt_s;
      mem_err_r   <= mem_err_nxt_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.wb_en     = wb_en_r;
  assign bus.wb_addr   = wb_addr_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.mem_err   = mem_err_r;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table driven through the stage, writebacks checked
// against a scoreboard queue, plus hand sequences for idle ack and mid-operation reset.
module tb_mem_wb_stage;
  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 8;
  localparam int REG_W   = 3;
  localparam int TIMEOUT = 15;
  localparam int NVEC    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  mem_wb_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] result;
    logic [15:0] sdata;
    logic [2:0]  rd;
    int          ack_delay;  // cycle of mem_req in which ack arrives; 0 = never
    logic [15:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  wb_t  sb_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every writeback pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.wb_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: actual wb_en=1 addr=%0d data=%0h required no writeback",
                 bus.wb_addr, bus.wb_data);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_addr", 32'(bus.wb_addr), 32'(e.rd));
        chk("wb_data", 32'(bus.wb_data), 32'(e.data));
      end
    end
  end

  task automatic run_op(input vec_t v);
    int   n;
    logic is_mem;
    logic has_wb;
    logic is_str;
    wb_t  e;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(bus.in_ready), 32'd1);
    is_str = (v.op == 3'b101);
    is_mem = (v.op == 3'b100) || is_str;
    has_wb = (v.op == 3'b000) || (v.op == 3'b001) || (v.op == 3'b100 && v.ack_delay > 0);
    bus.in_valid      = 1'b1;
    bus.in_opcode     = v.op;
    bus.in_result     = v.result;
    bus.in_store_data = v.sdata;
    bus.in_rd         = v.rd;
    if (has_wb) begin
      e.rd   = v.rd;
      e.data = (v.op == 3'b100) ? v.rdata : v.result;
      sb_q.push_back(e);
    end
    step();
    bus.in_valid      = 1'b0;
    bus.in_opcode     = 3'($urandom_range(7, 0));
    bus.in_result     = 16'($urandom);
    bus.in_store_data = 16'($urandom);
    bus.in_rd         = 3'($urandom_range(7, 0));
    if (!is_mem) begin
      chk("mem_req_alu", 32'(bus.mem_req), 32'd0);
      chk("ready_after_accept", 32'(bus.in_ready), has_wb ? 32'd0 : 32'd1);
      if (has_wb) begin
        step();
        chk("ready_after_wb", 32'(bus.in_ready), 32'd1);
        chk("wb_en_drop", 32'(bus.wb_en), 32'd0);
      end
    end else begin
      chk("mem_req_rise", 32'(bus.mem_req), 32'd1);
      chk("mem_we", 32'(bus.mem_we), 32'(is_str));
      chk("mem_addr", 32'(bus.mem_addr), 32'(v.result[ADDR_W-1:0]));
      if (is_str) chk("mem_wdata", 32'(bus.mem_wdata), 32'(v.sdata));
      if (v.ack_delay > 0) begin
        for (int k = 1; k < v.ack_delay; k++) begin
          step();
          chk("mem_req_hold", 32'(bus.mem_req), 32'd1);
          chk("mem_addr_hold", 32'(bus.mem_addr), 32'(v.result[ADDR_W-1:0]));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("no_err_on_ack", 32'(bus.mem_err), 32'd0);
        chk("ready_after_ack", 32'(bus.in_ready), is_str ? 32'd1 : 32'd0);
        if (!is_str) begin
          step();
          chk("ready_after_load_wb", 32'(bus.in_ready), 32'd1);
        end
      end else begin
        n = 1;
        while (bus.mem_req === 1'b1 && n < 40) begin
          step();
          if (bus.mem_req === 1'b1) n++;
        end
        chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
        chk("mem_err_pulse", 32'(bus.mem_err), 32'd1);
        chk("ready_after_timeout", 32'(bus.in_ready), 32'd1);
        step();
        chk("mem_err_drop", 32'(bus.mem_err), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 16'd42,   16'h0000, 3'd3, 0,  16'h0000};
    vecs[1] = '{3'b001, 16'hFFFE, 16'h0000, 3'd5, 0,  16'h0000};
    vecs[2] = '{3'b100, 16'h012A, 16'h0000, 3'd2, 3,  16'h1234};
    vecs[3] = '{3'b101, 16'd42,   16'hBEEF, 3'd1, 1,  16'h0000};
    vecs[4] = '{3'b100, 16'h0010, 16'h0000, 3'd1, 0,  16'h0000};
    vecs[5] = '{3'b100, 16'hFF80, 16'h0000, 3'd7, 15, 16'hCAFE};
    vecs[6] = '{3'b111, 16'h5555, 16'h0000, 3'd6, 0,  16'h0000};
    vecs[7] = '{3'b000, 16'h8000, 16'h0000, 3'd0, 0,  16'h0000};
    vecs[8] = '{3'b101, 16'hAB01, 16'h0F0F, 3'd4, 4,  16'h0000};
    vecs[9] = '{3'b100, 16'h00FF, 16'h0000, 3'd6, 1,  16'h0000};

    bus.in_valid      = 1'b0;
    bus.in_opcode     = 3'b000;
    bus.in_result     = 16'h0000;
    bus.in_store_data = 16'h0000;
    bus.in_rd         = 3'd0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 16'h0000;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_mem_err", 32'(bus.mem_err), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    step();
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
    step();
    chk("ready_first_edge", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

    // Ack while idle, then reset in the middle of a LOAD with a late ack after release.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h7777;
    step();
    bus.mem_ack = 1'b0;
    chk("idle_ack_no_req", 32'(bus.mem_req), 32'd0);
    chk("idle_ack_ready", 32'(bus.in_ready), 32'd1);

    bus.in_valid  = 1'b1;
    bus.in_opcode = 3'b100;
    bus.in_result = 16'h0033;
    bus.in_rd     = 3'd4;
    step();
    bus.in_valid = 1'b0;
    chk("rst_op_req", 32'(bus.mem_req), 32'd1);
    step();
    chk("rst_op_req_hold", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.mem_req), 32'd0);
    chk("async_ready_drop", 32'(bus.in_ready), 32'd0);
    step();
    step();
    rst_n         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h9999;
    step();
    bus.mem_ack = 1'b0;
    chk("late_ack_no_req", 32'(bus.mem_req), 32'd0);
    chk("late_ack_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("late_ack_no_wb", 32'(bus.wb_en), 32'd0);

    run_op('{3'b000, 16'h0102, 16'h0000, 3'd2, 0, 16'h0000});
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
